// File: rtl/vb_decoder.sv
// VB_DECODER: decodes a stream of 7-bit-group variable-length integers into groups of four.
// Optional malformed-integer detection is enabled by defining VB_DECODER_ERR_EN.
module vb_decoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_int4,
  output logic [DATA_W-1:0] out_int3,
  output logic [DATA_W-1:0] out_int2,
  output logic [DATA_W-1:0] out_int1,
  output logic              ready,
  output logic              err
);

  localparam int MAX_BYTES = (DATA_W + 6) / 7;
  localparam int CNT_W     = 4;
`ifdef VB_DECODER_ERR_EN
  localparam int SH_W      = DATA_W + 7;
`else
  localparam int SH_W      = DATA_W;
`endif

  typedef enum logic {
    S_FIRST = 1'b0,
    S_CONT  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [1:0]        idx_r, idx_s;
  logic [DATA_W-1:0] slot0_r, slot1_r, slot2_r;
  logic [DATA_W-1:0] slot0_s, slot1_s, slot2_s;
  logic [DATA_W-1:0] out4_s, out3_s, out2_s, out1_s;
  logic              ready_s, err_s;
  logic [DATA_W-1:0] base_s;
  logic [SH_W-1:0]   shifted_s;
  logic              bad_s;

  // Next-state, accumulator, slot and output computation for one accepted byte.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    slot0_s   = slot0_r;
    slot1_s   = slot1_r;
    slot2_s   = slot2_r;
    out4_s    = out_int4;
    out3_s    = out_int3;
    out2_s    = out_int2;
    out1_s    = out_int1;
    ready_s   = 1'b0;
    err_s     = 1'b0;
    base_s    = (state_r == S_CONT) ? acc_r : {DATA_W{1'b0}};
    shifted_s = SH_W'({base_s, in_byte[6:0]});
`ifdef VB_DECODER_ERR_EN
    // Overflow bits above DATA_W, or one byte too many for this width.
    bad_s = (|shifted_s[SH_W-1:DATA_W]) || (cnt_r >= CNT_W'(MAX_BYTES));
`else
    bad_s = 1'b0;
`endif
    if (in_valid) begin
      if (bad_s) begin
        err_s   = 1'b1;
        state_s = S_FIRST;
        acc_s   = {DATA_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = 2'd0;
      end else if (!in_byte[7]) begin
        state_s = S_CONT;
        acc_s   = shifted_s[DATA_W-1:0];
        cnt_s   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
      end else begin
        state_s = S_FIRST;
        acc_s   = {DATA_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = idx_r + 2'd1;
        case (idx_r)
          2'd0: slot0_s = shifted_s[DATA_W-1:0];
          2'd1: slot1_s = shifted_s[DATA_W-1:0];
          2'd2: slot2_s = shifted_s[DATA_W-1:0];
          2'd3: begin
            out4_s  = slot0_r;
            out3_s  = slot1_r;
            out2_s  = slot2_r;
            out1_s  = shifted_s[DATA_W-1:0];
            ready_s = 1'b1;
          end
          default: idx_s = 2'd0;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_FIRST;
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= 2'd0;
      slot0_r  <= {DATA_W{1'b0}};
      slot1_r  <= {DATA_W{1'b0}};
      slot2_r  <= {DATA_W{1'b0}};
      out_int4 <= {DATA_W{1'b0}};
      out_int3 <= {DATA_W{1'b0}};
      out_int2 <= {DATA_W{1'b0}};
      out_int1 <= {DATA_W{1'b0}};
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      slot0_r  <= slot0_s;
      slot1_r  <= slot1_s;
      slot2_r  <= slot2_s;
      out_int4 <= out4_s;
      out_int3 <= out3_s;
      out_int2 <= out2_s;
      out_int1 <= out1_s;
      ready    <= ready_s;
      err      <= err_s;
    end
  end

endmodule
